// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response channels between two requesters and the ALU arbiter
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_in1;
  logic [DATA_W-1:0] req0_in2;
  logic [CTRL_W-1:0] req0_control;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_in1;
  logic [DATA_W-1:0] req1_in2;
  logic [CTRL_W-1:0] req1_control;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_out;
  logic              rsp_zero;
  logic              rsp_neg;

  modport master (
    output req0_valid, req0_in1, req0_in2, req0_control,
    output req1_valid, req1_in1, req1_in2, req1_control,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_out, rsp_zero, rsp_neg
  );

  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_control,
    input  req1_valid, req1_in1, req1_in2, req1_control,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_out, rsp_zero, rsp_neg
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one external combinational ALU between two requesters
module alu_arbiter #(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 4,
  parameter int PRIO_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic PRIO_RST = (PRIO_INIT != 0);

  state_t            state;
  logic              prio;
  logic              owner;
  logic [DATA_W-1:0] in1_q;
  logic [DATA_W-1:0] in2_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              neg_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic              busy_q;

  logic grant;
  logic any_valid;
  logic owner_ready;

  // A lone requester wins outright; contention falls back to the priority bit.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant     = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;
    owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;
  end

  assign bus.req0_ready = (state == IDLE) & bus.req0_valid & ~grant;
  assign bus.req1_ready = (state == IDLE) & bus.req1_valid & grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prio         <= PRIO_RST;
      owner        <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      ctrl_q       <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner  <= grant;
            in1_q  <= grant ? bus.req1_in1 : bus.req0_in1;
            in2_q  <= grant ? bus.req1_in2 : bus.req0_in2;
            ctrl_q <= grant ? bus.req1_control : bus.req0_control;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_q        <= alu_out;
          zero_q       <= alu_zero;
          neg_q        <= alu_neg;
          rsp0_valid_q <= ~owner;
          rsp1_valid_q <= owner;
          state        <= RESP;
        end
        RESP: begin
          // Result is held until the owner takes it; nothing new is accepted meanwhile.
          if (owner_ready) begin
            prio         <= ~owner;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign alu_in1        = in1_q;
  assign alu_in2        = in2_q;
  assign alu_control    = ctrl_q;
  assign bus.rsp_out    = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_neg    = neg_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and response scoreboard
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_control;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_neg;
  logic        busy;

  alu_arbiter_if bus();

  alu_arbiter #(.DATA_W(32), .CTRL_W(4), .PRIO_INIT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_control(alu_control),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .busy       (busy)
  );

  // Stand-in for the external ALU; unknown codes give 0.
  always_comb begin
    case (alu_control)
      4'd0:    alu_out = alu_in1 + alu_in2;
      4'd1:    alu_out = alu_in1 << alu_in2[4:0];
      4'd2:    alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
      4'd3:    alu_out = {31'b0, alu_in1 < alu_in2};
      4'd4:    alu_out = alu_in1 ^ alu_in2;
      4'd5:    alu_out = alu_in1 >> alu_in2[4:0];
      4'd6:    alu_out = alu_in1 | alu_in2;
      4'd7:    alu_out = alu_in1 & alu_in2;
      4'd8:    alu_out = alu_in1 - alu_in2;
      4'd13:   alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
    alu_neg  = alu_out[31];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [31:0] out;
    logic        zero;
    logic        neg;
  } exp_t;

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] eo;
    logic        ez;
    logic        en;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rsp_overlap", {31'b0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_port", {31'b0, bus.rsp1_valid}, {31'b0, e.port});
          chk("rsp_out", bus.rsp_out, e.out);
          chk("rsp_zero", {31'b0, bus.rsp_zero}, {31'b0, e.zero});
          chk("rsp_neg", {31'b0, bus.rsp_neg}, {31'b0, e.neg});
        end
      end
    end
  end

  task automatic drive_req(input bit p, input bit v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
    if (p) begin
      bus.req1_valid = v; bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_control = c;
    end else begin
      bus.req0_valid = v; bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_control = c;
    end
  endtask

  task automatic issue(input bit p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                       input logic [31:0] eo, input logic ez, input logic en);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    drive_req(p, 1'b1, a, b, c);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (p ? bus.req1_ready : bus.req0_ready) begin
        sb.push_back('{p, eo, ez, en});
        ok = 1'b1;
      end
    end
    @(posedge clk); #1;
    drive_req(p, 1'b0, 32'd0, 32'd0, 4'd0);
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'd5,          32'd7,          4'd0,  32'd12,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'd3,          32'd5,          4'd8,  32'hFFFFFFFE,   1'b0, 1'b1};
    vecs[2]  = '{1'b0, 32'h000000F0,   32'h000000F0,   4'd4,  32'd0,          1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'd1,          32'd2,          4'd3,  32'd1,          1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'd9,          32'd9,          4'hF,  32'd0,          1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'hFF00FF00,   32'h0F0F0F0F,   4'd7,  32'h0F000F00,   1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'hFF00FF00,   32'h0F0F0F0F,   4'd6,  32'hFF0FFF0F,   1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'd0,          32'd1,          4'd8,  32'hFFFFFFFF,   1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'h7FFFFFFF,   32'd1,          4'd0,  32'h80000000,   1'b0, 1'b1};
    vecs[9]  = '{1'b1, 32'd1,          32'd31,         4'd1,  32'h80000000,   1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'h80000000,   32'd4,          4'd13, 32'hF8000000,   1'b0, 1'b1};

    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
    chk("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
    chk("rst_rsp_out", bus.rsp_out, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_control", {28'b0, alu_control}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single op latency: accept cycle 0, response cycle 2.
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'd5, 32'd7, 4'd0);
    @(negedge clk);
    chk("t1_req0_ready_c0", {31'b0, bus.req0_ready}, 32'd1);
    chk("t1_busy_c0", {31'b0, busy}, 32'd0);
    sb.push_back('{1'b0, 32'd12, 1'b0, 1'b0});
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("t1_busy_c1", {31'b0, busy}, 32'd1);
    chk("t1_rsp0_valid_c1", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("t1_alu_in1", alu_in1, 32'd5);
    chk("t1_alu_in2", alu_in2, 32'd7);
    @(negedge clk);
    chk("t1_rsp0_valid_c2", {31'b0, bus.rsp0_valid}, 32'd1);
    chk("t1_busy_c2", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_busy_c3", {31'b0, busy}, 32'd0);
    chk("t1_rsp0_valid_c3", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("t1_alu_hold", alu_in1, 32'd5);
    drain();

    // Simultaneous requests after reset: port 0 wins first.
    do_reset();
    fork
      issue(1'b0, 32'd3, 32'd5, 4'd8, 32'hFFFFFFFE, 1'b0, 1'b1);
      issue(1'b1, 32'h000000F0, 32'h000000F0, 4'd4, 32'd0, 1'b1, 1'b0);
    join
    drain();

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].eo, vecs[i].ez, vecs[i].en);
      drain();
    end

    // Backpressure: port 1 result held while port 0 waits.
    bus.rsp1_ready = 1'b0;
    issue(1'b1, 32'd100, 32'd23, 4'd0, 32'd123, 1'b0, 1'b0);
    drive_req(1'b0, 1'b1, 32'h000000A5, 32'h0000005A, 4'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_req0_ready_held", {31'b0, bus.req0_ready}, 32'd0);
      if (i >= 1) begin
        chk("t3_rsp1_valid_held", {31'b0, bus.rsp1_valid}, 32'd1);
        chk("t3_rsp_out_held", bus.rsp_out, 32'd123);
      end
    end
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    chk("t3_req0_ready_release", {31'b0, bus.req0_ready}, 32'd0);
    @(negedge clk);
    chk("t3_req0_ready_idle", {31'b0, bus.req0_ready}, 32'd1);
    if (bus.req0_ready) sb.push_back('{1'b0, 32'h000000FF, 1'b0, 1'b0});
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drain();

    // Continuous contention: grants alternate 0,1,0,1 three cycles apart.
    do_reset();
    begin
      int g;
      int last_c;
      g = 0;
      last_c = 0;
      @(posedge clk); #1;
      drive_req(1'b0, 1'b1, 32'd1, 32'd1, 4'd0);
      drive_req(1'b1, 1'b1, 32'd2, 32'd2, 4'd0);
      for (int c = 0; c < 40 && g < 4; c++) begin
        @(negedge clk);
        if (bus.req0_ready || bus.req1_ready) begin
          chk("t4_one_grant", {31'b0, bus.req0_ready & bus.req1_ready}, 32'd0);
          chk("t4_grant_order", {31'b0, bus.req1_ready}, g % 2);
          if (g > 0) chk("t4_grant_spacing", c - last_c, 32'd3);
          last_c = c;
          if (bus.req1_ready) sb.push_back('{1'b1, 32'd4, 1'b0, 1'b0});
          else                sb.push_back('{1'b0, 32'd2, 1'b0, 1'b0});
          g++;
        end
      end
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
      chk("t4_grant_count", g, 32'd4);
    end
    drain();

    // Reset during EXEC drops the op and clears outputs asynchronously.
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'd44, 32'd4, 4'd8);
    @(negedge clk);
    chk("t5_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    chk("t5_busy_exec", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", {31'b0, busy}, 32'd0);
    chk("t5_rsp0_valid_rst", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("t5_rsp_out_rst", bus.rsp_out, 32'd0);
    chk("t5_alu_in1_rst", alu_in1, 32'd0);
    chk("t5_alu_control_rst", {28'b0, alu_control}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", {31'b0, bus.rsp0_valid | bus.rsp1_valid}, 32'd0);
    end
    issue(1'b1, 32'd1, 32'd2, 4'd3, 32'd1, 1'b0, 1'b0);
    drain();

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
